// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 Hz timing for the VGA raster generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned COORD_LIMIT = 1024;

    // Registered output bundle; field order is the bit order of the flop.
    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   visible;
        logic   hsync;
        logic   vsync;
        logic   vga_clk;
        logic   pix_tick;
        logic   line_start;
        logic   frame_start;
    } vga_out_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe and active/sync region decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   adv,
    output coord_t count,
    output logic   wrap,
    output logic   in_active,
    output logic   in_sync
);

    localparam int unsigned TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam int unsigned SYNC_LO = ACTIVE + FP;
    localparam int unsigned SYNC_HI = ACTIVE + FP + SYNC;

    coord_t      count_q, count_d;
    logic [31:0] count_ext;

    always_comb begin
        count_ext = 32'(count_q);
        wrap      = adv && (count_ext == TOTAL - 1);
        count_d   = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (adv) begin
            count_d = count_q + coord_t'(1);
        end
        in_active = (count_ext < ACTIVE);
        in_sync   = (count_ext >= SYNC_LO) && (count_ext < SYNC_HI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters and registered decode of
// coordinates, syncs, DAC control and game-logic strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    output coord_t x,
    output coord_t y,
    output logic   visible,
    output logic   hsync,
    output logic   vsync,
    output logic   vga_clk,
    output logic   blank_n,
    output logic   sync_n,
    output logic   pix_tick,
    output logic   line_start,
    output logic   frame_start
);

    localparam int unsigned H_SUM = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_SUM = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    if (H_SUM > COORD_LIMIT || V_SUM > COORD_LIMIT) begin : g_total_check
        $error("vga_timing_gen: line or frame total exceeds 1024");
    end
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be even and at least 2");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    coord_t           hcnt, vcnt;
    logic             h_wrap, v_wrap, v_adv;
    logic             h_active, v_active, h_sync_on, v_sync_on;
    logic             line_pend_q, line_pend_d;
    logic             frame_pend_q, frame_pend_d;
    vga_out_t         out_q, out_d, out_rst;

    always_comb begin
        tick  = (32'(div_q) == CLK_DIV - 1);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    assign v_adv = h_wrap && tick;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (tick),
        .count     (hcnt),
        .wrap      (h_wrap),
        .in_active (h_active),
        .in_sync   (h_sync_on)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (v_adv),
        .count     (vcnt),
        .wrap      (v_wrap),
        .in_active (v_active),
        .in_sync   (v_sync_on)
    );

    // Wrap strobes are remembered one clk so they line up with the registered x = 0.
    always_comb begin
        line_pend_d  = v_adv;
        frame_pend_d = v_adv && v_wrap;

        out_rst       = '0;
        out_rst.hsync = ~SYNC_POL;
        out_rst.vsync = ~SYNC_POL;

        out_d             = out_rst;
        out_d.x           = hcnt;
        out_d.y           = vcnt;
        out_d.visible     = h_active && v_active;
        out_d.hsync       = h_sync_on ? SYNC_POL : ~SYNC_POL;
        out_d.vsync       = v_sync_on ? SYNC_POL : ~SYNC_POL;
        out_d.vga_clk     = (32'(div_q) >= CLK_DIV / 2);
        out_d.pix_tick    = tick;
        out_d.line_start  = line_pend_q;
        out_d.frame_start = frame_pend_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q        <= '0;
            line_pend_q  <= 1'b0;
            frame_pend_q <= 1'b0;
            out_q        <= out_rst;
        end else begin
            div_q        <= div_d;
            line_pend_q  <= line_pend_d;
            frame_pend_q <= frame_pend_d;
            out_q        <= out_d;
        end
    end

    assign x           = out_q.x;
    assign y           = out_q.y;
    assign visible     = out_q.visible;
    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign vga_clk     = out_q.vga_clk;
    assign blank_n     = out_q.visible;
    assign sync_n      = 1'b0;
    assign pix_tick    = out_q.pix_tick;
    assign line_start  = out_q.line_start;
    assign frame_start = out_q.frame_start;

endmodule
